// File: rtl/pengo_dl_ctrl_pkg.sv
// Shared types and constants for the Pengo ROM download controller.
package pengo_dl_ctrl_pkg;

    // Controller states: waiting for a download, loading, reset hold, core running.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } dl_state_t;

    // Bit positions inside the one-hot region write strobe.
    localparam int REG_CPU  = 0;
    localparam int REG_GFX  = 1;
    localparam int REG_PROM = 2;

    // Default region boundaries (first address past each region).
    localparam logic [15:0] DEF_CPU_END  = 16'h8000;
    localparam logic [15:0] DEF_GFX_END  = 16'hC000;
    localparam logic [15:0] DEF_PROM_END = 16'hC220;

    // Default number of reset-hold cycles.
    localparam int DEF_HOLD_CYC = 1024;

    // Byte counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [16:0] sat_inc17(input logic [16:0] val);
        if (val == 17'h1FFFF) begin
            return val;
        end else begin
            return val + 17'd1;
        end
    endfunction

endpackage

// File: rtl/pengo_dl_ctrl_if.sv
// ioctl download bus from hps_io plus the registered dn_* write bus to the core.
interface pengo_dl_ctrl_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [2:0]  dn_wr;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/pengo_rst_hold.sv
// Loadable down-counter timing the core reset-hold window.
module pengo_rst_hold #(
    parameter int HOLD_CYC = 1024,
    parameter int CW       = $clog2(HOLD_CYC + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          load_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o,
    output logic          last_o
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload wins over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(HOLD_CYC);
        end else if (dec_i && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register; reset starts a full hold window.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= CW'(HOLD_CYC);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == {CW{1'b0}});
    // The decrement taken this cycle brings the count to zero.
    assign last_o = (cnt_q <= CW'(1));
endmodule

// File: rtl/pengo_dl_ctrl.sv
// Pengo ROM download sequencer: region strobes, byte counting, error flags and core reset.
module pengo_dl_ctrl
    import pengo_dl_ctrl_pkg::*;
#(
    parameter logic [15:0] CPU_END  = DEF_CPU_END,
    parameter logic [15:0] GFX_END  = DEF_GFX_END,
    parameter logic [15:0] PROM_END = DEF_PROM_END,
    parameter int          HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              user_reset_i,
    pengo_dl_ctrl_if.slave    bus,
    output logic              core_reset_o,
    output logic              dl_done_o,
    output logic              dl_err_o,
    output logic [16:0]       byte_cnt_o
);
    localparam int CW = $clog2(HOLD_CYC + 1);

    dl_state_t   state_q, state_d;
    logic [15:0] dn_addr_q, dn_addr_d;
    logic [7:0]  dn_data_q, dn_data_d;
    logic [2:0]  dn_wr_q, dn_wr_d;
    logic        core_reset_q;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [16:0] cnt_q, cnt_d;
    logic        hold_load_s, hold_dec_s;
    logic        hold_last_s, hold_zero_s;
    logic [CW-1:0] hold_cnt_s;
    logic        accept_s;
    logic [2:0]  region_s;
    logic        overflow_s;

    pengo_rst_hold #(.HOLD_CYC(HOLD_CYC), .CW(CW)) u_hold (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (hold_load_s),
        .dec_i   (hold_dec_s),
        .cnt_o   (hold_cnt_s),
        .zero_o  (hold_zero_s),
        .last_o  (hold_last_s)
    );

    // Bytes are taken whenever the download window is open, so a byte arriving
    // with the rising window is kept and one arriving as it falls is dropped.
    assign accept_s = bus.ioctl_download & bus.ioctl_wr;

    // Region decode on the full 25-bit address; anything past the PROMs is overflow.
    always_comb begin
        region_s   = 3'b000;
        overflow_s = 1'b0;
        if (bus.ioctl_addr < {9'd0, CPU_END}) begin
            region_s[REG_CPU] = 1'b1;
        end else if (bus.ioctl_addr < {9'd0, GFX_END}) begin
            region_s[REG_GFX] = 1'b1;
        end else if (bus.ioctl_addr < {9'd0, PROM_END}) begin
            region_s[REG_PROM] = 1'b1;
        end else begin
            overflow_s = 1'b1;
        end
    end

    // Next-state, hold-counter control, status flags and write path.
    always_comb begin
        state_d     = state_q;
        hold_load_s = 1'b0;
        hold_dec_s  = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        dn_wr_d     = 3'b000;
        dn_addr_d   = dn_addr_q;
        dn_data_d   = dn_data_q;

        if (bus.ioctl_download && (state_q != ST_LOAD)) begin
            state_d = ST_LOAD;
            cnt_d   = 17'd0;
            err_d   = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOAD: begin
                    if (!bus.ioctl_download) begin
                        state_d     = ST_HOLD;
                        hold_load_s = 1'b1;
                        done_d      = 1'b1;
                        err_d       = err_q | (cnt_q < {1'b0, PROM_END});
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (user_reset_i) begin
                        hold_load_s = 1'b1;
                    end else if (hold_last_s || hold_zero_s) begin
                        hold_dec_s = 1'b1;
                        state_d    = done_q ? ST_RUN : ST_IDLE;
                    end else begin
                        hold_dec_s = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (user_reset_i) begin
                        state_d     = ST_HOLD;
                        hold_load_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (accept_s) begin
            cnt_d = sat_inc17(cnt_d);
            if (overflow_s) begin
                err_d = 1'b1;
            end else begin
                dn_wr_d   = region_s;
                dn_addr_d = bus.ioctl_addr[15:0];
                dn_data_d = bus.ioctl_dout;
            end
        end else begin
            dn_wr_d = 3'b000;
        end
    end

    // State, flags and the registered write bus; reset aborts any transfer in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_HOLD;
            core_reset_q <= 1'b1;
            dn_wr_q      <= 3'b000;
            dn_addr_q    <= 16'h0000;
            dn_data_q    <= 8'h00;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 17'd0;
        end else begin
            state_q      <= state_d;
            core_reset_q <= (state_d != ST_RUN);
            dn_wr_q      <= dn_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.dn_addr   = dn_addr_q;
    assign bus.dn_data   = dn_data_q;
    assign bus.dn_wr     = dn_wr_q;
    assign core_reset_o  = core_reset_q;
    assign dl_done_o     = done_q;
    assign dl_err_o      = err_q;
    assign byte_cnt_o    = cnt_q;
endmodule

// File: tb/tb_pengo_dl_ctrl.sv
// Directed self-checking bench for pengo_dl_ctrl.
module tb_pengo_dl_ctrl;
    import pengo_dl_ctrl_pkg::*;

    localparam int HOLD = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        user_reset = 1'b0;
    logic        core_reset;
    logic        dl_done;
    logic        dl_err;
    logic [16:0] byte_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    pengo_dl_ctrl_if bus();

    pengo_dl_ctrl dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .user_reset_i (user_reset),
        .bus          (bus),
        .core_reset_o (core_reset),
        .dl_done_o    (dl_done),
        .dl_err_o     (dl_err),
        .byte_cnt_o   (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts clock edges until core_reset drops, giving up after 2000.
    task automatic wait_release(output int n);
        n = 0;
        while ((core_reset === 1'b1) && (n < 2000)) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [2:0] exp_region(input int a);
        if (a < 32'h8000) return 3'b001;
        else if (a < 32'hC000) return 3'b010;
        else if (a < 32'hC220) return 3'b100;
        else return 3'b000;
    endfunction

    initial begin
        int n;
        int bad;

        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;

        // Power-up: one reset cycle, no download.
        tick();
        check("rst_state", 32'(dut.state_q), 32'(ST_HOLD));
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_dn_wr", 32'(bus.dn_wr), 32'd0);
        check("rst_dn_addr", 32'(bus.dn_addr), 32'd0);
        check("rst_dn_data", 32'(bus.dn_data), 32'd0);
        check("rst_done", 32'(dl_done), 32'd0);
        check("rst_err", 32'(dl_err), 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("rst_hold_cnt", 32'(dut.u_hold.cnt_q), 32'(HOLD));
        reset = 1'b0;
        repeat (1100) tick();
        check("pwr_idle_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("pwr_core_reset", 32'(core_reset), 32'd1);
        check("pwr_done", 32'(dl_done), 32'd0);

        // Full load; first byte arrives in the same cycle the window opens.
        bus.ioctl_download = 1'b1;
        bad = 0;
        for (int i = 0; i < 32'hC220; i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = 8'(i) ^ 8'h5A;
            tick();
            if ((bus.dn_wr !== exp_region(i)) || (bus.dn_addr !== 16'(i)) ||
                (bus.dn_data !== (8'(i) ^ 8'h5A))) begin
                bad++;
            end
            if ((i == 0) || (i == 32'h7FFF) || (i == 32'h8000) || (i == 32'hBFFF) ||
                (i == 32'hC000) || (i == 32'hC21F)) begin
                check($sformatf("full_dn_wr_%0h", i), 32'(bus.dn_wr), 32'(exp_region(i)));
            end
        end
        check("full_bad_writes", 32'(bad), 32'd0);
        bus.ioctl_wr = 1'b0;
        tick();
        check("full_strobe_one_cycle", 32'(bus.dn_wr), 32'd0);
        check("full_byte_cnt", 32'(byte_cnt), 32'hC220);
        check("full_err", 32'(dl_err), 32'd0);
        check("full_state_load", 32'(dut.state_q), 32'(ST_LOAD));
        bus.ioctl_download = 1'b0;
        wait_release(n);
        check("full_release_cycles", 32'(n), 32'(HOLD + 1));
        check("full_done", 32'(dl_done), 32'd1);
        check("full_err_after", 32'(dl_err), 32'd0);
        check("full_state_run", 32'(dut.state_q), 32'(ST_RUN));

        // A write outside the download window is ignored.
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h10;
        tick();
        bus.ioctl_wr = 1'b0;
        check("nowin_dn_wr", 32'(bus.dn_wr), 32'd0);
        check("nowin_byte_cnt", 32'(byte_cnt), 32'hC220);

        // Overflow bytes: no strobe, sticky error, still counted.
        bus.ioctl_download = 1'b1;
        bus.ioctl_wr       = 1'b1;
        bus.ioctl_addr     = 25'h00C220;
        tick();
        check("ovf1_dn_wr", 32'(bus.dn_wr), 32'd0);
        check("ovf1_err", 32'(dl_err), 32'd1);
        check("ovf1_byte_cnt", 32'(byte_cnt), 32'd1);
        check("ovf1_done", 32'(dl_done), 32'd0);
        check("ovf1_core_reset", 32'(core_reset), 32'd1);
        bus.ioctl_addr = 25'h0010000;
        tick();
        check("ovf2_dn_wr", 32'(bus.dn_wr), 32'd0);
        check("ovf2_err", 32'(dl_err), 32'd1);
        check("ovf2_byte_cnt", 32'(byte_cnt), 32'd2);
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        tick();

        // Short load of 0x100 bytes; a byte in the closing cycle is dropped.
        bus.ioctl_download = 1'b1;
        bad = 0;
        for (int i = 0; i < 32'h100; i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = 8'(i);
            tick();
            if ((bus.dn_wr !== 3'b001) || (bus.dn_addr !== 16'(i))) bad++;
        end
        check("short_bad_writes", 32'(bad), 32'd0);
        check("short_err_cleared", 32'(dl_err), 32'd0);
        bus.ioctl_addr     = 25'h100;
        bus.ioctl_download = 1'b0;
        tick();
        bus.ioctl_wr = 1'b0;
        check("short_fall_dn_wr", 32'(bus.dn_wr), 32'd0);
        check("short_byte_cnt", 32'(byte_cnt), 32'h100);
        check("short_done", 32'(dl_done), 32'd1);
        check("short_err", 32'(dl_err), 32'd1);
        wait_release(n);
        // One edge of the window was already taken by the tick above.
        check("short_release_cycles", 32'(n), 32'(HOLD));
        check("short_err_in_run", 32'(dl_err), 32'd1);

        // User reset held for 5 cycles while running.
        user_reset = 1'b1;
        tick();
        check("ures_core_reset", 32'(core_reset), 32'd1);
        repeat (4) tick();
        user_reset = 1'b0;
        wait_release(n);
        check("ures_release_cycles", 32'(n), 32'(HOLD));
        check("ures_dn_wr", 32'(bus.dn_wr), 32'd0);
        check("ures_err_kept", 32'(dl_err), 32'd1);

        // Reset in the middle of a load with the window still open.
        bus.ioctl_download = 1'b1;
        for (int i = 0; i < 32'h50; i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(i);
            tick();
        end
        check("mid_byte_cnt", 32'(byte_cnt), 32'h50);
        bus.ioctl_addr = 25'h50;
        reset = 1'b1;
        tick();
        check("mid_rst_dn_wr", 32'(bus.dn_wr), 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'(ST_HOLD));
        reset = 1'b0;
        bus.ioctl_wr = 1'b0;
        tick();
        check("mid_reload_state", 32'(dut.state_q), 32'(ST_LOAD));
        check("mid_reload_cnt", 32'(byte_cnt), 32'd0);
        check("mid_reload_dn_wr", 32'(bus.dn_wr), 32'd0);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h51;
        bus.ioctl_dout = 8'hA5;
        tick();
        bus.ioctl_wr = 1'b0;
        check("mid_dn_wr", 32'(bus.dn_wr), 32'd1);
        check("mid_dn_addr", 32'(bus.dn_addr), 32'h51);
        check("mid_dn_data", 32'(bus.dn_data), 32'hA5);
        check("mid_byte_cnt1", 32'(byte_cnt), 32'd1);
        bus.ioctl_download = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
